// File: rtl/sevenseg_msg_seq.sv
// sevenseg_msg_seq
// ----------------
// Message scheduler for the four-digit seven-segment driver. It cycles
// through the board messages SCoC, TEST, 2017 and GAPH. Each message is held
// for DWELL cycles, and a blank gap of BLANK cycles separates messages.
// A push button advances the rotation by hand, and a pause input freezes
// the dwell/blank timer.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     synchronous reset, active-low
//   enable    1 = run; 0 = blank display and restart the sequence
//   pause     1 = hold the dwell/blank timer (button still acts)
//   btn_next  raw push button, asynchronous to clk, active-high
//   digit0-3  registered digit codes, digit0 leftmost (4'hF = space)
//   decplace  decimal-point position, always equal to msg_idx
//   msg_idx   current message: 0=SCoC 1=TEST 2=2017 3=GAPH
//   wrap      one-cycle pulse when msg_idx advances 3->0
//
// States
//   ST_BLANK | all digits blank, timing the gap before the next message
//   ST_SHOW  | current message displayed, timing its dwell
module sevenseg_msg_seq #(
  parameter int DWELL = 100000000,
  parameter int BLANK = 12500000,
  parameter int CNT_W = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       pause,
  input  logic       btn_next,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [1:0] decplace,
  output logic [1:0] msg_idx,
  output logic       wrap
);

  localparam logic ST_BLANK = 1'b0;
  localparam logic ST_SHOW  = 1'b1;

  localparam logic [15:0] DIGITS_BLANK = 16'hFFFF;

  // With BLANK == 0 the gap state is only passed through once after reset
  // or enable, and message-to-message advances go straight SHOW->SHOW.
  localparam logic BLANK_EN = (BLANK != 0);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK > 0) ? CNT_W'(BLANK - 1) : '0;
  localparam logic [CNT_W-1:0] TIMER_ONE  = CNT_W'(1);

  function automatic logic [15:0] msg_code(input logic [1:0] idx);
    logic [15:0] code;
    case (idx)
      2'd0:    code = 16'h1023;
      2'd1:    code = 16'hCDEC;
      2'd2:    code = 16'h4567;
      default: code = 16'h89AB;
    endcase
    return code;
  endfunction

  // Button synchroniser: s1/s2 resolve metastability, s3 is the edge
  // detector's history. No debounce here; every rising edge is a press.
  logic s1_q, s2_q, s3_q;
  logic press;

  logic             state_q,  state_d;
  logic [CNT_W-1:0] timer_q,  timer_d;
  logic [1:0]       idx_q,    idx_d;
  logic             wrap_q,   wrap_d;
  logic [15:0]      digits_q, digits_d;

  logic blank_done;
  logic dwell_done;

  assign press = s2_q & ~s3_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= btn_next;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign blank_done = ~BLANK_EN | (~pause & (timer_q == BLANK_LAST));
  assign dwell_done = ~pause & (timer_q == DWELL_LAST);

  // A press and a timer expiry on the same cycle collapse into one advance
  // because both feed the same transition condition.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    idx_d    = idx_q;
    wrap_d   = 1'b0;
    digits_d = digits_q;

    if (!enable) begin
      state_d  = ST_BLANK;
      timer_d  = '0;
      idx_d    = 2'd0;
      digits_d = DIGITS_BLANK;
    end else begin
      case (state_q)
        ST_BLANK: begin
          if (blank_done || press) begin
            state_d  = ST_SHOW;
            timer_d  = '0;
            digits_d = msg_code(idx_q);
          end else if (!pause) begin
            timer_d = timer_q + TIMER_ONE;
          end
        end

        ST_SHOW: begin
          if (dwell_done || press) begin
            idx_d   = idx_q + 2'd1;
            wrap_d  = (idx_q == 2'd3);
            timer_d = '0;
            if (BLANK_EN) begin
              state_d  = ST_BLANK;
              digits_d = DIGITS_BLANK;
            end else begin
              state_d  = ST_SHOW;
              digits_d = msg_code(idx_q + 2'd1);
            end
          end else if (!pause) begin
            timer_d = timer_q + TIMER_ONE;
          end
        end

        default: begin
          state_d  = ST_BLANK;
          timer_d  = '0;
          digits_d = DIGITS_BLANK;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_BLANK;
      timer_q  <= '0;
      idx_q    <= 2'd0;
      wrap_q   <= 1'b0;
      digits_q <= DIGITS_BLANK;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      wrap_q   <= wrap_d;
      digits_q <= digits_d;
    end
  end

  assign digit0   = digits_q[15:12];
  assign digit1   = digits_q[11:8];
  assign digit2   = digits_q[7:4];
  assign digit3   = digits_q[3:0];
  assign msg_idx  = idx_q;
  assign decplace = idx_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_sevenseg_msg_seq.sv
// tb_sevenseg_msg_seq
// Directed scenarios followed by randomized stimulus. A reference model
// tracks the displayed message and the cycles left in the current phase,
// and every cycle the DUT outputs are compared against it.
module tb_sevenseg_msg_seq;

  localparam int DWELL = 8;
  localparam int BLANK = 2;
  localparam int CNT_W = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic       pause = 1'b0;
  logic       btn_next = 1'b0;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic [1:0] decplace, msg_idx;
  logic       wrap;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_model = 1'b0;

  wire [15:0] dig_all = {digit0, digit1, digit2, digit3};

  sevenseg_msg_seq #(
    .DWELL(DWELL),
    .BLANK(BLANK),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .pause    (pause),
    .btn_next (btn_next),
    .digit0   (digit0),
    .digit1   (digit1),
    .digit2   (digit2),
    .digit3   (digit3),
    .decplace (decplace),
    .msg_idx  (msg_idx),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] msg_tab [4] = '{16'h1023, 16'hCDEC, 16'h4567, 16'h89AB};
  bit m_show;
  int m_idx;
  int m_left;    // cycles still to spend in the current phase
  bit m_wrap;
  bit hist[$] = '{1'b0, 1'b0, 1'b0};  // btn samples, oldest first
  bit m_press;

  task automatic model_restart();
    m_show = 1'b0;
    m_idx  = 0;
    m_left = BLANK;
    m_wrap = 1'b0;
  endtask

  always @(posedge clk) begin
    // a rising edge seen two samples back is acted on now
    m_press = hist[1] & ~hist[0];
    if (!rst_n) begin
      hist = '{1'b0, 1'b0, 1'b0};
      model_restart();
    end else begin
      hist.push_back(btn_next);
      void'(hist.pop_front());
      m_wrap = 1'b0;
      if (!enable) begin
        model_restart();
      end else if (!m_show) begin
        if (m_press || BLANK == 0 || (!pause && m_left == 1)) begin
          m_show = 1'b1;
          m_left = DWELL;
        end else if (!pause) begin
          m_left--;
        end
      end else begin
        if (m_press || (!pause && m_left == 1)) begin
          m_wrap = (m_idx == 3);
          m_idx  = (m_idx + 1) % 4;
          m_show = (BLANK == 0);
          m_left = m_show ? DWELL : BLANK;
        end else if (!pause) begin
          m_left--;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_model) begin
      check_val("model_digits", 32'(dig_all), 32'(m_show ? msg_tab[m_idx] : 16'hFFFF));
      check_val("model_msg_idx", 32'(msg_idx), 32'(m_idx));
      check_val("model_decplace", 32'(decplace), 32'(m_idx));
      check_val("model_wrap", 32'(wrap), 32'(m_wrap));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
  endtask

  task automatic expect_out(input string tag, input logic [15:0] dig, input logic [1:0] idx);
    check_val({tag, "_digits"}, 32'(dig_all), 32'(dig));
    check_val({tag, "_idx"}, 32'(msg_idx), 32'(idx));
  endtask

  initial begin
    rst_n = 1'b0;
    step(2);
    chk_model = 1'b1;
    rst_n = 1'b1;

    // release from reset: 2 blank, 8 SCoC, 2 blank, TEST
    expect_out("p1_reset", 16'hFFFF, 2'd0);
    check_val("p1_reset_wrap", 32'(wrap), 32'd0);
    step(1); expect_out("p1_blank1", 16'hFFFF, 2'd0);
    step(1); expect_out("p1_show_first", 16'h1023, 2'd0);
    step(7); expect_out("p1_show_last", 16'h1023, 2'd0);
    step(1); expect_out("p1_gap", 16'hFFFF, 2'd1);
    step(2); expect_out("p1_test", 16'hCDEC, 2'd1);
    check_val("p1_decplace", 32'(decplace), 32'd1);

    // held button in mid-SHOW: one advance after two edges
    do_reset();
    step(5);
    btn_next = 1'b1;
    step(2); expect_out("p3_latency", 16'h1023, 2'd0);
    step(1); expect_out("p3_advance", 16'hFFFF, 2'd1);
    step(2); expect_out("p3_held", 16'hCDEC, 2'd1);
    btn_next = 1'b0;
    step(3); expect_out("p3_single", 16'hCDEC, 2'd1);

    // press coinciding with dwell expiry counts once
    do_reset();
    step(7);
    btn_next = 1'b1;
    step(2); expect_out("p5_before", 16'h1023, 2'd0);
    step(1); expect_out("p5_advance", 16'hFFFF, 2'd1);
    btn_next = 1'b0;
    step(12); expect_out("p5_next", 16'h4567, 2'd2);

    // pause during SHOW idx2 stretches the dwell by the paused cycles
    step(3);
    pause = 1'b1;
    step(20); expect_out("p4_paused", 16'h4567, 2'd2);
    pause = 1'b0;
    step(4); expect_out("p4_resume", 16'h4567, 2'd2);
    step(1); expect_out("p4_done", 16'hFFFF, 2'd3);
    step(2); expect_out("p4_gaph", 16'h89AB, 2'd3);

    // press while paused still advances; wrap pulses on 3->0
    pause = 1'b1;
    btn_next = 1'b1;
    step(3); expect_out("p4_press_pause", 16'hFFFF, 2'd0);
    check_val("p2_wrap_pulse", 32'(wrap), 32'd1);
    step(1); check_val("p2_wrap_single", 32'(wrap), 32'd0);
    step(4); expect_out("p4_blank_held", 16'hFFFF, 2'd0);
    pause = 1'b0;
    btn_next = 1'b0;
    step(2); expect_out("p4_scoc", 16'h1023, 2'd0);

    // walk to GAPH by presses, then drop enable
    for (int i = 0; i < 3; i++) begin
      btn_next = 1'b1;
      step(1);
      btn_next = 1'b0;
      step(5);
    end
    expect_out("p6_gaph", 16'h89AB, 2'd3);
    enable = 1'b0;
    step(1); expect_out("p6_disable", 16'hFFFF, 2'd0);
    check_val("p6_disable_wrap", 32'(wrap), 32'd0);
    enable = 1'b1;
    step(1); expect_out("p6_reen_blank", 16'hFFFF, 2'd0);
    step(1); expect_out("p6_reen_show", 16'h1023, 2'd0);

    // mid-operation reset
    step(3);
    do_reset();
    expect_out("p6_reset", 16'hFFFF, 2'd0);

    // randomized traffic, model checked every cycle
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 11) == 0) btn_next = ~btn_next;
      if ($urandom_range(0, 29) == 0) pause = ~pause;
      if (enable) begin
        if ($urandom_range(0, 149) == 0) enable = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        enable = 1'b1;
      end
      rst_n = ($urandom_range(0, 399) != 0);
      step(1);
    end

    chk_model = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sevenseg_msg_seq.md
Name: sevenseg_msg_seq

Overview:
Message scheduler for the four-digit seven-segment driver. It drives the driver's digit0..digit3 and decplace inputs. It rotates through the four board messages SCoC, TEST, 2017 and GAPH, holding each for a programmable dwell time with a blank gap between messages. A user button advances the rotation manually, and a pause input freezes it. It sits between top-level board I/O (button, switches) and the seven-segment driver, in the same clock domain.

Parameters:
DWELL, 100000000, clock cycles each message is shown (>=1)
BLANK, 12500000, clock cycles of blank display between messages (0 = no blank state)
CNT_W, 27, timer width; must satisfy 2^CNT_W > max(DWELL, BLANK)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous reset, active-low
enable  input  1  1 = sequencer running; 0 = display blanked, sequence restarted
pause  input  1  1 = freeze the dwell/blank timer; the button still acts
btn_next  input  1  raw push-button, asynchronous to clk, active-high
digit0  output  4  leftmost digit code to the driver (registered)
digit1  output  4  digit code (registered)
digit2  output  4  digit code (registered)
digit3  output  4  rightmost digit code (registered)
decplace  output  2  decimal-point position to the driver; equals msg_idx
msg_idx  output  2  current message index: 0=SCoC, 1=TEST, 2=2017, 3=GAPH
wrap  output  1  one-cycle pulse when msg_idx advances 3->0

Behaviour:
- Reset is synchronous, active-low, one clock, single-edge effective, and valid mid-operation. State=BLANK, timer=0, msg_idx=0, decplace=0, wrap=0, all digits=4'hF (driver shows space). Button synchroniser flops are cleared to 0.
- Digit codes per message, as digit0,digit1,digit2,digit3:
  - idx0 SCoC = 1,0,2,3
  - idx1 TEST = C,D,E,C
  - idx2 2017 = 4,5,6,7
  - idx3 GAPH = 8,9,A,B
  - Blank = F,F,F,F.
- Button path:
  - 2-flop synchroniser (s1, s2), plus a delay flop s3.
  - press = s2 & ~s3: one pulse per rising edge of btn_next.
  - No debounce in this block; a bounced button gives multiple presses.
  - Latency: a rising edge of btn_next ahead of clock edge k is acted on at edge k+2; outputs show the change after edge k+2.
- FSM states: BLANK and SHOW. The timer is CNT_W bits.
- BLANK state:
  - Digits = F.
  - If BLANK == 0, go to SHOW on the next edge.
  - Otherwise, when the timer reaches BLANK-1 (and pause=0), or on press: go to SHOW, timer <= 0, digits <= message[msg_idx].
  - Otherwise, if pause=0: timer <= timer+1.
- SHOW state:
  - Digits = message[msg_idx].
  - When the timer reaches DWELL-1 (and pause=0), or on press:
    - msg_idx <= msg_idx+1 (mod 4); wrap=1 for that one cycle if msg_idx was 3.
    - timer <= 0.
    - Next state is BLANK, or SHOW with the new message if BLANK == 0.
  - Otherwise, if pause=0: timer <= timer+1.
- Simultaneous timer expiry and press: treated as ONE advance, never two.
- pause=1 holds the timer and state. A press is still honoured, and the timer restarts from 0 in the new state.
- enable=0 has priority over press and timer. Next edge: state=BLANK, timer=0, msg_idx=0, digits=F, wrap=0.
- Rising enable starts a fresh blank period, then idx0 (same as after reset).
- decplace is registered and updated on the same edge as msg_idx.
- Digits, msg_idx and wrap all change on the same edge as the state transition; no extra output pipeline stage.

Test Plan:
Bench parameters: DWELL=8, BLANK=2, enable=1, pause=0, btn_next=0.
1. Release reset -> digits=F for 2 cycles, then 1,0,2,3 with msg_idx=0 for exactly 8 cycles, then F for 2 cycles, then C,D,E,C with msg_idx=1, decplace=1.
2. Free-run 4 full messages -> sequence idx 0,1,2,3,0; wrap=1 for exactly one cycle, coincident with msg_idx 3->0; GAPH shows as 8,9,A,B.
3. Raise btn_next in mid-SHOW of idx0, hold 5 cycles -> 2 edges later digits=F and msg_idx=1; only one advance for the held press.
4. pause=1 during SHOW idx2 for 20 cycles -> digits stay 4,5,6,7; after pause=0 the remaining dwell cycles complete (total shown = 8 + 20 cycles); a press during pause advances to idx3.
5. Press timed so it coincides with the DWELL-1 expiry -> msg_idx increments by exactly 1.
6. Drop enable, or assert rst_n=0 for one cycle, during SHOW idx3 -> next edge digits=F, msg_idx=0, wrap=0; on re-enable, 2 blank cycles then SCoC.
